// File: rtl/mc_controller_if.sv
// Memory handshake bundle between the multi-cycle controller and the
// instruction/data memories. Both memories may take any number of cycles
// to answer; the controller holds its request until the ready arrives.
interface mc_controller_if;
    logic imem_req;
    logic imem_ready;
    logic dmem_req;
    logic dmem_we;
    logic dmem_ready;

    // Controller side: issues requests, waits for ready
    modport master (
        output imem_req,
        output dmem_req,
        output dmem_we,
        input  imem_ready,
        input  dmem_ready
    );

    // Memory side: sees requests, returns ready
    modport slave (
        input  imem_req,
        input  dmem_req,
        input  dmem_we,
        output imem_ready,
        output dmem_ready
    );
endinterface

// File: rtl/mc_controller.sv
// Multi-cycle control FSM for the word-addressed MIPS-style datapath.
// Sequences fetch/decode/execute/memory/writeback, generates datapath
// strobes, waits on variable-latency memories, counts retired
// instructions and traps permanently on an undefined opcode.
module mc_controller (
    input  logic            clk,
    input  logic            rst_n,
    mc_controller_if.master mem,
    input  logic [5:0]      opcode,
    input  logic            alu_zero,
    output logic            ir_write,
    output logic            pc_write,
    output logic [1:0]      pc_src,
    output logic            reg_write,
    output logic [1:0]      reg_dst,
    output logic [1:0]      wb_src,
    output logic            alu_src_b,
    output logic [1:0]      alu_op,
    output logic            illegal,
    output logic [3:0]      state,
    output logic [31:0]     instret
);

    localparam logic [5:0] OP_R    = 6'b000000;
    localparam logic [5:0] OP_LW   = 6'b100011;
    localparam logic [5:0] OP_SW   = 6'b101011;
    localparam logic [5:0] OP_BEQ  = 6'b000100;
    localparam logic [5:0] OP_BNE  = 6'b000101;
    localparam logic [5:0] OP_ADDI = 6'b001000;
    localparam logic [5:0] OP_J    = 6'b000010;
    localparam logic [5:0] OP_JAL  = 6'b000011;

    typedef enum logic [3:0] {
        S_START    = 4'd0,
        S_FETCH    = 4'd1,
        S_DECODE   = 4'd2,
        S_EXEC_R   = 4'd3,
        S_EXEC_I   = 4'd4,
        S_MEM_ADDR = 4'd5,
        S_MEM_RD   = 4'd6,
        S_MEM_WR   = 4'd7,
        S_WB_R     = 4'd8,
        S_WB_I     = 4'd9,
        S_WB_MEM   = 4'd10,
        S_BRANCH   = 4'd11,
        S_JUMP     = 4'd12,
        S_TRAP     = 4'd13
    } state_t;

    state_t      state_q;
    state_t      state_d;
    logic [5:0]  op_q;
    logic [31:0] instret_q;
    logic        retire;

    // State register
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= S_START;
        end else begin
            state_q <= state_d;
        end
    end

    // Capture the opcode in DECODE so later states ignore IR-bus changes
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            op_q <= 6'd0;
        end else if (state_q == S_DECODE) begin
            op_q <= opcode;
        end
    end

    // Retired-instruction counter, wraps naturally at 2^32
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            instret_q <= 32'd0;
        end else if (retire) begin
            instret_q <= instret_q + 32'd1;
        end
    end

    // Next-state and strobe decode; every output defaults to idle
    always_comb begin
        state_d      = state_q;
        retire       = 1'b0;
        mem.imem_req = 1'b0;
        mem.dmem_req = 1'b0;
        mem.dmem_we  = 1'b0;
        ir_write     = 1'b0;
        pc_write     = 1'b0;
        pc_src       = 2'b00;
        reg_write    = 1'b0;
        reg_dst      = 2'b00;
        wb_src       = 2'b00;
        alu_src_b    = 1'b0;
        alu_op       = 2'b00;
        illegal      = 1'b0;

        case (state_q)
            S_START: begin
                state_d = S_FETCH;
            end
            S_FETCH: begin
                mem.imem_req = 1'b1;
                if (mem.imem_ready) begin
                    ir_write = 1'b1;
                    pc_write = 1'b1;
                    pc_src   = 2'b00;
                    state_d  = S_DECODE;
                end
            end
            S_DECODE: begin
                case (opcode)
                    OP_R:          state_d = S_EXEC_R;
                    OP_ADDI:       state_d = S_EXEC_I;
                    OP_LW, OP_SW:  state_d = S_MEM_ADDR;
                    OP_BEQ, OP_BNE: state_d = S_BRANCH;
                    OP_J, OP_JAL:  state_d = S_JUMP;
                    default:       state_d = S_TRAP;
                endcase
            end
            S_EXEC_R: begin
                alu_op  = 2'b10;
                state_d = S_WB_R;
            end
            S_EXEC_I: begin
                alu_src_b = 1'b1;
                alu_op    = 2'b00;
                state_d   = S_WB_I;
            end
            S_MEM_ADDR: begin
                alu_src_b = 1'b1;
                alu_op    = 2'b00;
                state_d   = (op_q == OP_SW) ? S_MEM_WR : S_MEM_RD;
            end
            S_MEM_RD: begin
                mem.dmem_req = 1'b1;
                if (mem.dmem_ready) begin
                    state_d = S_WB_MEM;
                end
            end
            S_MEM_WR: begin
                mem.dmem_req = 1'b1;
                mem.dmem_we  = 1'b1;
                if (mem.dmem_ready) begin
                    retire  = 1'b1;
                    state_d = S_FETCH;
                end
            end
            S_WB_R: begin
                reg_write = 1'b1;
                reg_dst   = 2'b01;
                wb_src    = 2'b00;
                retire    = 1'b1;
                state_d   = S_FETCH;
            end
            S_WB_I: begin
                reg_write = 1'b1;
                reg_dst   = 2'b00;
                wb_src    = 2'b00;
                retire    = 1'b1;
                state_d   = S_FETCH;
            end
            S_WB_MEM: begin
                reg_write = 1'b1;
                reg_dst   = 2'b00;
                wb_src    = 2'b01;
                retire    = 1'b1;
                state_d   = S_FETCH;
            end
            S_BRANCH: begin
                alu_op   = 2'b01;
                pc_src   = 2'b01;
                pc_write = ((op_q == OP_BEQ) &&  alu_zero) ||
                           ((op_q == OP_BNE) && !alu_zero);
                retire   = 1'b1;
                state_d  = S_FETCH;
            end
            S_JUMP: begin
                pc_write = 1'b1;
                pc_src   = 2'b10;
                if (op_q == OP_JAL) begin
                    reg_write = 1'b1;
                    reg_dst   = 2'b10;
                    wb_src    = 2'b10;
                end
                retire  = 1'b1;
                state_d = S_FETCH;
            end
            S_TRAP: begin
                // Absorbing: only reset leaves this state
                illegal = 1'b1;
                state_d = S_TRAP;
            end
            default: begin
                state_d = S_START;
            end
        endcase
    end

    assign state   = state_q;
    assign instret = instret_q;

endmodule

// File: tb/tb_mc_controller.sv
// Bench for mc_controller: a reference model derives each instruction's
// state walk and per-state strobe table from the opcode and random memory
// wait counts, then compares the DUT cycle by cycle.
module tb_mc_controller;

    localparam logic [5:0] OP_R    = 6'b000000;
    localparam logic [5:0] OP_LW   = 6'b100011;
    localparam logic [5:0] OP_SW   = 6'b101011;
    localparam logic [5:0] OP_BEQ  = 6'b000100;
    localparam logic [5:0] OP_BNE  = 6'b000101;
    localparam logic [5:0] OP_ADDI = 6'b001000;
    localparam logic [5:0] OP_J    = 6'b000010;
    localparam logic [5:0] OP_JAL  = 6'b000011;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic [5:0]  opcode = 6'd0;
    logic        alu_zero = 1'b0;
    logic        ir_write, pc_write, reg_write, alu_src_b, illegal;
    logic [1:0]  pc_src, reg_dst, wb_src, alu_op;
    logic [3:0]  state;
    logic [31:0] instret;

    int          total = 0;
    int          bad = 0;
    logic [31:0] instret_m = 32'd0;

    mc_controller_if mem ();

    mc_controller dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .mem       (mem),
        .opcode    (opcode),
        .alu_zero  (alu_zero),
        .ir_write  (ir_write),
        .pc_write  (pc_write),
        .pc_src    (pc_src),
        .reg_write (reg_write),
        .reg_dst   (reg_dst),
        .wb_src    (wb_src),
        .alu_src_b (alu_src_b),
        .alu_op    (alu_op),
        .illegal   (illegal),
        .state     (state),
        .instret   (instret)
    );

    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog expired total=%0d bad=%0d", total, bad);
        $fatal(1, "watchdog");
    end

    function automatic logic is_legal(input logic [5:0] op);
        return (op == OP_R) || (op == OP_LW) || (op == OP_SW) || (op == OP_BEQ) ||
               (op == OP_BNE) || (op == OP_ADDI) || (op == OP_J) || (op == OP_JAL);
    endfunction

    function automatic logic [5:0] rand_legal_op();
        case ($urandom_range(0, 7))
            0: return OP_R;
            1: return OP_LW;
            2: return OP_SW;
            3: return OP_BEQ;
            4: return OP_BNE;
            5: return OP_ADDI;
            6: return OP_J;
            default: return OP_JAL;
        endcase
    endfunction

    // Strobe table from the instruction-set description:
    // {imem_req,dmem_req,dmem_we,ir_write,pc_write,pc_src,reg_write,reg_dst,wb_src,alu_src_b,alu_op,illegal}
    function automatic logic [15:0] exp_out(input int st, input logic [5:0] op,
                                            input logic ir, input logic zero);
        logic imr, dr, dwe, irw, pcw, rw, asb, ill;
        logic [1:0] ps, rd, wb, ao;
        imr = 0; dr = 0; dwe = 0; irw = 0; pcw = 0; rw = 0; asb = 0; ill = 0;
        ps = 0; rd = 0; wb = 0; ao = 0;
        case (st)
            1:  begin imr = 1; irw = ir; pcw = ir; end
            3:  ao = 2'b10;
            4:  asb = 1;
            5:  asb = 1;
            6:  dr = 1;
            7:  begin dr = 1; dwe = 1; end
            8:  begin rw = 1; rd = 2'b01; end
            9:  rw = 1;
            10: begin rw = 1; wb = 2'b01; end
            11: begin
                    ao = 2'b01; ps = 2'b01;
                    pcw = ((op == OP_BEQ) && zero) || ((op == OP_BNE) && !zero);
                end
            12: begin
                    pcw = 1; ps = 2'b10;
                    if (op == OP_JAL) begin rw = 1; rd = 2'b10; wb = 2'b10; end
                end
            13: ill = 1;
            default: ;
        endcase
        return {imr, dr, dwe, irw, pcw, ps, rw, rd, wb, asb, ao, ill};
    endfunction

    function automatic logic [15:0] dut_vec();
        return {mem.imem_req, mem.dmem_req, mem.dmem_we, ir_write, pc_write, pc_src,
                reg_write, reg_dst, wb_src, alu_src_b, alu_op, illegal};
    endfunction

    task automatic rand_inputs();
        opcode         = 6'($urandom);
        alu_zero       = 1'($urandom);
        mem.imem_ready = 1'($urandom);
        mem.dmem_ready = 1'($urandom);
    endtask

    // Hold reset, release on a falling edge, end just after the edge that enters FETCH
    task automatic reset_seq(input string name);
        rst_n = 1'b0;
        rand_inputs();
        repeat (2) @(negedge clk);
        total++;
        if (state !== 4'd0 || instret !== 32'd0 || dut_vec() !== 16'd0) begin
            bad++;
            $display("FAIL %s_held state=%0d outs=%h instret=%h required state=0 outs=0 instret=0",
                     name, state, dut_vec(), instret);
        end
        instret_m = 32'd0;
        rst_n = 1'b1;
        #1;
        total++;
        if (state !== 4'd0 || dut_vec() !== 16'd0) begin
            bad++;
            $display("FAIL %s_first_cycle state=%0d outs=%h required state=0 outs=0",
                     name, state, dut_vec());
        end
        @(posedge clk);
        #1;
    endtask

    // Run one instruction starting in FETCH; iw/dw are memory wait cycles
    task automatic run_instr(input string name, input logic [5:0] op,
                             input int iw, input int dw, input logic zero);
        int   st_q[$];
        bit   rdy_q[$];
        int   st;
        st_q.delete();
        rdy_q.delete();
        for (int i = 0; i < iw; i++) begin st_q.push_back(1); rdy_q.push_back(0); end
        st_q.push_back(1); rdy_q.push_back(1);
        st_q.push_back(2); rdy_q.push_back(0);
        case (op)
            OP_R:    begin st_q.push_back(3); st_q.push_back(8); rdy_q.push_back(0); rdy_q.push_back(0); end
            OP_ADDI: begin st_q.push_back(4); st_q.push_back(9); rdy_q.push_back(0); rdy_q.push_back(0); end
            OP_LW, OP_SW: begin
                st_q.push_back(5); rdy_q.push_back(0);
                for (int i = 0; i < dw; i++) begin
                    st_q.push_back(op == OP_LW ? 6 : 7); rdy_q.push_back(0);
                end
                st_q.push_back(op == OP_LW ? 6 : 7); rdy_q.push_back(1);
                if (op == OP_LW) begin st_q.push_back(10); rdy_q.push_back(0); end
            end
            OP_BEQ, OP_BNE: begin st_q.push_back(11); rdy_q.push_back(0); end
            OP_J, OP_JAL:   begin st_q.push_back(12); rdy_q.push_back(0); end
            default:        ;
        endcase
        for (int k = 0; k < st_q.size(); k++) begin
            st = st_q[k];
            opcode         = (st <= 2) ? op : 6'($urandom);
            alu_zero       = (st == 11) ? zero : 1'($urandom);
            mem.imem_ready = (st == 1) ? rdy_q[k] : 1'($urandom);
            mem.dmem_ready = (st == 6 || st == 7) ? rdy_q[k] : 1'($urandom);
            @(negedge clk);
            total++;
            if (state !== 4'(st)) begin
                bad++;
                $display("FAIL %s_state cyc=%0d got=%0d required=%0d", name, k, state, st);
            end
            total++;
            if (dut_vec() !== exp_out(st, op, mem.imem_ready, alu_zero)) begin
                bad++;
                $display("FAIL %s_outs cyc=%0d st=%0d got=%h required=%h", name, k, st,
                         dut_vec(), exp_out(st, op, mem.imem_ready, alu_zero));
            end
            total++;
            if (instret !== instret_m) begin
                bad++;
                $display("FAIL %s_instret_mid cyc=%0d got=%h required=%h", name, k, instret, instret_m);
            end
            @(posedge clk);
            #1;
        end
        if (is_legal(op)) begin
            instret_m = instret_m + 32'd1;
            total++;
            if (state !== 4'd1 || instret !== instret_m) begin
                bad++;
                $display("FAIL %s_retire state=%0d instret=%h required state=1 instret=%h",
                         name, state, instret, instret_m);
            end
        end else begin
            total++;
            if (state !== 4'd13) begin
                bad++;
                $display("FAIL %s_trap_entry state=%0d required=13", name, state);
            end
        end
    endtask

    task automatic test_reset();
        reset_seq("reset");
        run_instr("first_r", OP_R, 0, 0, 1'b0);
    endtask

    task automatic test_lw_wait();
        run_instr("lw_wait3", OP_LW, 0, 3, 1'b0);
        run_instr("lw_iwait", OP_LW, 2, 0, 1'b0);
        run_instr("sw_wait", OP_SW, 1, 2, 1'b0);
    endtask

    task automatic test_branches();
        run_instr("beq_taken", OP_BEQ, 0, 0, 1'b1);
        run_instr("bne_nottaken", OP_BNE, 0, 0, 1'b1);
        run_instr("bne_taken", OP_BNE, 1, 0, 1'b0);
        run_instr("beq_nottaken", OP_BEQ, 0, 0, 1'b0);
    endtask

    task automatic test_jumps();
        run_instr("jal", OP_JAL, 0, 0, 1'b0);
        run_instr("j", OP_J, 1, 0, 1'b0);
        run_instr("addi", OP_ADDI, 0, 0, 1'b0);
    endtask

    task automatic test_random();
        for (int n = 0; n < 60; n++) begin
            run_instr("rand", rand_legal_op(), $urandom_range(0, 3), $urandom_range(0, 3),
                      1'($urandom));
        end
    endtask

    task automatic test_trap();
        run_instr("trap", 6'b111111, 0, 0, 1'b0);
        for (int k = 0; k < 10; k++) begin
            rand_inputs();
            @(negedge clk);
            total++;
            if (state !== 4'd13 || dut_vec() !== 16'h0001) begin
                bad++;
                $display("FAIL trap_hold cyc=%0d state=%0d outs=%h required state=13 outs=0001",
                         k, state, dut_vec());
            end
            @(posedge clk);
            #1;
        end
        #2;
        rst_n = 1'b0;
        #1;
        total++;
        if (illegal !== 1'b0 || state !== 4'd0 || dut_vec() !== 16'd0) begin
            bad++;
            $display("FAIL trap_async_clear illegal=%b state=%0d outs=%h required 0/0/0",
                     illegal, state, dut_vec());
        end
        reset_seq("trap_reset");
    endtask

    task automatic test_reset_mid_write();
        run_instr("pre_sw", OP_ADDI, 0, 0, 1'b0);
        opcode = OP_SW; mem.imem_ready = 1'b1; mem.dmem_ready = 1'b0;
        repeat (3) begin @(posedge clk); #1; end
        mem.dmem_ready = 1'b0;
        @(negedge clk);
        total++;
        if (state !== 4'd7 || mem.dmem_req !== 1'b1 || mem.dmem_we !== 1'b1) begin
            bad++;
            $display("FAIL midwr_setup state=%0d dmem_req=%b dmem_we=%b required 7/1/1",
                     state, mem.dmem_req, mem.dmem_we);
        end
        #2;
        rst_n = 1'b0;
        #1;
        total++;
        if (mem.dmem_req !== 1'b0 || state !== 4'd0 || instret !== 32'd0) begin
            bad++;
            $display("FAIL midwr_abort dmem_req=%b state=%0d instret=%h required 0/0/0",
                     mem.dmem_req, state, instret);
        end
        reset_seq("midwr_reset");
        run_instr("after_abort", OP_SW, 0, 0, 1'b0);
    endtask

    task automatic test_wrap();
        rst_n = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
        force dut.instret_q = 32'hFFFF_FFFF;
        @(posedge clk);
        #1;
        release dut.instret_q;
        instret_m = 32'hFFFF_FFFF;
        total++;
        if (instret !== 32'hFFFF_FFFF || state !== 4'd1) begin
            bad++;
            $display("FAIL wrap_preload instret=%h state=%0d required ffffffff/1", instret, state);
        end
        run_instr("wrap_r", OP_R, 0, 0, 1'b0);
        total++;
        if (instret !== 32'd0) begin
            bad++;
            $display("FAIL wrap_zero instret=%h required 00000000", instret);
        end
    endtask

    initial begin
        mem.imem_ready = 1'b0;
        mem.dmem_ready = 1'b0;
        test_reset();
        test_lw_wait();
        test_branches();
        test_jumps();
        test_random();
        test_trap();
        test_reset_mid_write();
        test_wrap();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/mc_controller.md
# mc_controller

Multi-cycle control FSM for the word-addressed MIPS-style datapath. It sequences each instruction through fetch, decode, execute, memory and writeback, and drives the program counter write strobe and next-PC select (PC+1, branch, jump), register-file and memory strobes, and ALU setup. It handshakes with instruction and data memories that have variable latency, counts retired instructions, and traps on undefined opcodes.

## Interface
- No parameters.
- clk  in  1  system clock, rising-edge.
- rst_n  in  1  asynchronous active-low reset.
- opcode  in  6  instruction[31:26] from the instruction register; sampled in DECODE.
- alu_zero  in  1  ALU zero flag; consumed only in BRANCH.
- imem_ready  in  1  instruction word valid this cycle.
- dmem_ready  in  1  data access complete this cycle.
- imem_req  out  1  instruction fetch request.
- dmem_req  out  1  data access request.
- dmem_we  out  1  data write, valid with dmem_req.
- ir_write  out  1  load the instruction register.
- pc_write  out  1  load PC with the selected next-PC.
- pc_src  out  2  next-PC select: 00 = PC+1, 01 = PC+sext(imm16) (PC already incremented), 10 = {PC[31:28],2'b0,instr[25:0]}.
- reg_write  out  1  register-file write.
- reg_dst  out  2  destination select: 00 = rt, 01 = rd, 10 = r31.
- wb_src  out  2  writeback source: 00 = ALU, 01 = memory, 10 = PC.
- alu_src_b  out  1  0 = rt, 1 = sext(imm16).
- alu_op  out  2  00 = add, 01 = subtract, 10 = decode funct.
- illegal  out  1  sticky trap flag.
- state  out  4  current state encoding, for debug.
- instret  out  32  retired-instruction count.

## Operation
- Opcodes: R 000000, lw 100011, sw 101011, beq 000100, bne 000101, addi 001000, j 000010, jal 000011. Any other opcode is illegal.
- State encodings: START 0, FETCH 1, DECODE 2, EXEC_R 3, EXEC_I 4, MEM_ADDR 5, MEM_RD 6, MEM_WR 7, WB_R 8, WB_I 9, WB_MEM 10, BRANCH 11, JUMP 12, TRAP 13.
- All outputs default to 0 unless listed for a state.
- START: all outputs 0. Next state is FETCH.
- FETCH: imem_req=1. When imem_ready=1: ir_write=1, pc_write=1, pc_src=00, next state DECODE. Otherwise the FSM stays in FETCH.
- DECODE: latch opcode internally, then dispatch:
  - R → EXEC_R
  - addi → EXEC_I
  - lw/sw → MEM_ADDR
  - beq/bne → BRANCH
  - j/jal → JUMP
  - other → TRAP
- EXEC_R: alu_op=10. Next state WB_R, which drives reg_write=1, reg_dst=01, wb_src=00, then FETCH.
- EXEC_I: alu_src_b=1, alu_op=00. Next state WB_I, which drives reg_write=1, reg_dst=00, wb_src=00, then FETCH.
- MEM_ADDR: alu_src_b=1, alu_op=00. Next state is MEM_RD for lw, MEM_WR for sw.
- MEM_RD: dmem_req=1; hold until dmem_ready, then WB_MEM. WB_MEM drives reg_write=1, reg_dst=00, wb_src=01, then FETCH.
- MEM_WR: dmem_req=1, dmem_we=1; hold until dmem_ready, then FETCH.
- BRANCH: alu_op=01, pc_src=01. pc_write = (beq & alu_zero) | (bne & ~alu_zero). Next state FETCH.
- JUMP: pc_write=1, pc_src=10. For jal only, also reg_write=1, reg_dst=10, wb_src=10. Next state FETCH.
- TRAP: illegal=1 and no strobes. The FSM stays in TRAP until reset.
- instret: 32-bit counter, wraps from 0xFFFFFFFF to 0. Increments by 1 on every transition into FETCH from WB_R, WB_I, WB_MEM, MEM_WR, BRANCH or JUMP. A not-taken branch counts.

## Timing
- Reset values: state=START, instret=0, illegal=0. Every strobe is 0 while rst_n=0 and during the first cycle after release.
- Reset assertion is asynchronous. All strobes drop in the same cycle, and any pending imem or dmem request is abandoned without completion.
- The first imem_req appears in the second cycle after rst_n rises.
- Strobes are combinational from state and latched opcode. Ready-qualified strobes (ir_write, pc_write in FETCH) and alu_zero-qualified pc_write are combinational on those inputs in the same cycle.
- Latency with zero-wait memories (ready high in the first request cycle), counted from FETCH through the retiring state:
  - R / addi / lw: 4 / 4 / 5 cycles
  - sw: 4 cycles
  - beq/bne: 3 cycles
  - j/jal: 3 cycles
- Each wait cycle (ready low) adds one cycle and holds every output stable.
- A change of opcode after DECODE has no effect, because dispatch and pc_write use the latched value.

## Test plan
- Reset, then rst_n high with imem_ready=1 and opcode=R: state sequence 0,1,2,3,8,1. reg_write=1 with reg_dst=01 only in WB_R; instret=1 on re-entering FETCH.
- lw with dmem_ready low for 3 cycles: MEM_RD held 4 cycles with dmem_req=1 and dmem_we=0. WB_MEM then drives wb_src=01 and reg_dst=00.
- Branches:
  - beq with alu_zero=1: pc_write=1 and pc_src=01 in BRANCH.
  - bne with alu_zero=1: pc_write=0, but instret still increments.
- jal: JUMP drives pc_write=1, pc_src=10, reg_write=1, reg_dst=10, wb_src=10.
- opcode=111111: DECODE→TRAP, illegal=1 and held through 10 further cycles with no strobes. rst_n low clears illegal immediately.
- rst_n pulsed low mid-MEM_WR: dmem_req drops the same cycle and state=0. Preload instret to 0xFFFFFFFF via a long run or force, retire one instruction, and expect instret=0.
